// File: rtl/sram_march_bist.sv
// rtl/sram_march_bist.sv - Wishbone classic master running a March C- test over one SRAM window
//
// Sequence (idx = word index):
//   M0 up w0 | M1 up r0,w1 | M2 up r1,w0 | M3 down r0,w1 | M4 down r1,w0 | M5 up r0
// FSM: IDLE -> ISSUE -> WAIT_ACK -> GAP -> (ISSUE | DONE) -> IDLE
//
// Ports:
//   wb_clk_i, wb_rst_n_i      clock, asynchronous active-low reset
//   start_i                   one-cycle start pulse, honoured only in IDLE
//   busy_o, done_o, pass_o    run status; done_o is sticky until the next accepted start
//   err_cnt_o                 saturating read-mismatch count
//   fail_addr/exp/act_o       byte address, expected and read data of the first mismatch
//   timeout_o                 sticky ack-watchdog flag
//   wbm_*                     Wishbone classic master interface
//
// Optional feature: define SRAM_BIST_TIMEOUT_EN to enable the ack watchdog
// (TIMEOUT_CYC wait cycles without ack aborts the run with timeout_o=1).

module sram_march_bist #(
    parameter int          ADDR_WORDS  = 16384,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] DATA_BG     = 32'h0000_0000,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [15:0] err_cnt_o,
    output logic [31:0] fail_addr_o,
    output logic [31:0] fail_exp_o,
    output logic [31:0] fail_act_o,
    output logic        timeout_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam int            IW       = $clog2(ADDR_WORDS);
    localparam logic [IW-1:0] IDX_LAST = IW'(ADDR_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_GAP,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    elem_q, elem_d;     // march element M0..M5
    logic          op_q, op_d;         // 0 = first op of element, 1 = second
    logic [IW-1:0] idx_q, idx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [15:0]   err_cnt_q, err_cnt_d;
    logic [31:0]   fail_addr_q, fail_addr_d;
    logic [31:0]   fail_exp_q, fail_exp_d;
    logic [31:0]   fail_act_q, fail_act_d;
    logic          cyc_q, cyc_d;
    logic          stb_q, stb_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic          timeout_now;

    // Current operation decode
    logic        single_op;
    logic        elem_down;
    logic        op_is_write;
    logic        pat_one;
    logic [31:0] pattern;
    logic        at_elem_end;

    always_comb begin
        single_op   = (elem_q == 3'd0) || (elem_q == 3'd5);
        elem_down   = (elem_q == 3'd3) || (elem_q == 3'd4);
        op_is_write = (elem_q == 3'd0) ? 1'b1 : (elem_q == 3'd5) ? 1'b0 : op_q;
        // Writes of "1" occur in M1/M3; reads expect "1" in M2/M4.
        pat_one     = op_is_write ? ((elem_q == 3'd1) || (elem_q == 3'd3))
                                  : ((elem_q == 3'd2) || (elem_q == 3'd4));
        pattern     = pat_one ? ~DATA_BG : DATA_BG;
        at_elem_end = elem_down ? (idx_q == '0) : (idx_q == IDX_LAST);
    end

`ifdef SRAM_BIST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          timeout_q, timeout_d;
    assign timeout_now = timeout_q;
    assign timeout_o   = timeout_q;
`else
    assign timeout_now = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        op_d        = op_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_cnt_d   = err_cnt_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_act_d  = fail_act_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
`ifdef SRAM_BIST_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        timeout_d   = timeout_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    err_cnt_d   = '0;
                    fail_addr_d = '0;
                    fail_exp_d  = '0;
                    fail_act_d  = '0;
`ifdef SRAM_BIST_TIMEOUT_EN
                    timeout_d   = 1'b0;
`endif
                    elem_d      = 3'd0;
                    op_d        = 1'b0;
                    idx_d       = '0;
                    state_d     = S_ISSUE;
                end
            end

            S_ISSUE: begin
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
                we_d    = op_is_write;
                sel_d   = 4'hF;
                adr_d   = BASE_ADDR + (32'(idx_q) << 2);
                dat_d   = op_is_write ? pattern : 32'h0;
`ifdef SRAM_BIST_TIMEOUT_EN
                to_cnt_d = '0;
`endif
                state_d = S_WAIT_ACK;
            end

            S_WAIT_ACK: begin
                if (wbm_ack_i) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    we_d  = 1'b0;
                    sel_d = 4'h0;
                    adr_d = '0;
                    dat_d = '0;
                    if (!we_q && (wbm_dat_i != pattern)) begin
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end
                        // Count is cleared at start, so zero means no mismatch seen yet.
                        if (err_cnt_q == 16'h0) begin
                            fail_addr_d = adr_q;
                            fail_exp_d  = pattern;
                            fail_act_d  = wbm_dat_i;
                        end
                    end
                    state_d = S_GAP;
                end
`ifdef SRAM_BIST_TIMEOUT_EN
                else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    we_d      = 1'b0;
                    sel_d     = 4'h0;
                    adr_d     = '0;
                    dat_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
`endif
            end

            S_GAP: begin
                state_d = S_ISSUE;
                if (!single_op && !op_q) begin
                    op_d = 1'b1;
                end else begin
                    op_d = 1'b0;
                    if (at_elem_end) begin
                        if (elem_q == 3'd5) begin
                            state_d = S_DONE;
                        end else begin
                            elem_d = elem_q + 3'd1;
                            // M3 and M4 (entered from M2/M3) walk downwards.
                            idx_d  = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? IDX_LAST : '0;
                        end
                    end else begin
                        idx_d = elem_down ? (idx_q - IW'(1)) : (idx_q + IW'(1));
                    end
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_cnt_q == 16'h0) && !timeout_now;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= S_IDLE;
            elem_q      <= '0;
            op_q        <= 1'b0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
`ifdef SRAM_BIST_TIMEOUT_EN
            to_cnt_q    <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_act_q  <= fail_act_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
`ifdef SRAM_BIST_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign err_cnt_o   = err_cnt_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_exp_o  = fail_exp_q;
    assign fail_act_o  = fail_act_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = stb_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// tb/tb_sram_march_bist.sv - directed self-checking bench for sram_march_bist

module tb_sram_march_bist;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A: BASE 0x10000, background 0 ----------------
    logic        a_start = 1'b0;
    logic        a_busy, a_done, a_pass, a_timeout;
    logic [15:0] a_err;
    logic [31:0] a_faddr, a_fexp, a_fact;
    logic        a_cyc, a_stb, a_we, a_ack;
    logic [3:0]  a_sel;
    logic [31:0] a_adr, a_dat_o, a_dat_i;
    logic [31:0] a_mem [8];
    logic [2:0]  a_widx;
    logic        a_stuck = 1'b0;
    logic        a_noack = 1'b0;
    int          a_waits = 0;
    int          a_wcnt = 0;
    int          a_xfers = 0, a_selbad = 0, a_idlebad = 0, a_holdbad = 0, a_cyccnt = 0;
    logic        a_prev_wait = 1'b0;
    logic [71:0] a_prev_bus = '0;

    sram_march_bist #(
        .ADDR_WORDS(8), .BASE_ADDR(32'h0001_0000), .DATA_BG(32'h0), .TIMEOUT_CYC(16)
    ) u_dut_a (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(a_start),
        .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass), .err_cnt_o(a_err),
        .fail_addr_o(a_faddr), .fail_exp_o(a_fexp), .fail_act_o(a_fact),
        .timeout_o(a_timeout),
        .wbm_cyc_o(a_cyc), .wbm_stb_o(a_stb), .wbm_we_o(a_we), .wbm_sel_o(a_sel),
        .wbm_adr_o(a_adr), .wbm_dat_o(a_dat_o), .wbm_dat_i(a_dat_i), .wbm_ack_i(a_ack)
    );

    assign a_widx  = 3'((a_adr - 32'h0001_0000) >> 2);
    assign a_dat_i = a_mem[a_widx] | ((a_stuck && a_widx == 3'd5) ? 32'h1 : 32'h0);
    assign a_ack   = a_cyc & a_stb & ~a_noack & (a_wcnt == a_waits);

    always @(posedge clk) begin
        if (a_cyc && a_stb && !a_ack) a_wcnt <= a_wcnt + 1;
        else                          a_wcnt <= 0;
        if (a_ack && a_we) a_mem[a_widx] <= a_dat_o;
    end

    always @(negedge clk) begin
        if (a_cyc && a_stb && a_ack) begin
            a_xfers <= a_xfers + 1;
            if (a_sel !== 4'hF) a_selbad <= a_selbad + 1;
        end
        if (!a_stb && (a_dat_o !== 32'h0 || a_we !== 1'b0)) a_idlebad <= a_idlebad + 1;
        if (a_prev_wait && ({a_adr, a_dat_o, a_we, a_sel, a_cyc, a_stb, 1'b0} !== a_prev_bus))
            a_holdbad <= a_holdbad + 1;
        a_prev_wait <= a_cyc & a_stb & ~a_ack;
        a_prev_bus  <= {a_adr, a_dat_o, a_we, a_sel, a_cyc, a_stb, 1'b0};
        if (a_cyc) a_cyccnt <= a_cyccnt + 1;
    end

    // ---------------- instance B: BASE 0, background A5A55A5A ----------------
    logic        b_start = 1'b0;
    logic        b_busy, b_done, b_pass, b_timeout;
    logic [15:0] b_err;
    logic [31:0] b_faddr, b_fexp, b_fact;
    logic        b_cyc, b_stb, b_we, b_ack;
    logic [3:0]  b_sel;
    logic [31:0] b_adr, b_dat_o, b_dat_i;
    logic [31:0] b_mem [8];
    logic [2:0]  b_widx;
    logic [31:0] b_log_adr [80];
    logic [31:0] b_log_dat [80];
    logic        b_log_we  [80];
    int          b_n = 0;

    sram_march_bist #(
        .ADDR_WORDS(8), .BASE_ADDR(32'h0), .DATA_BG(32'hA5A5_5A5A), .TIMEOUT_CYC(16)
    ) u_dut_b (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(b_start),
        .busy_o(b_busy), .done_o(b_done), .pass_o(b_pass), .err_cnt_o(b_err),
        .fail_addr_o(b_faddr), .fail_exp_o(b_fexp), .fail_act_o(b_fact),
        .timeout_o(b_timeout),
        .wbm_cyc_o(b_cyc), .wbm_stb_o(b_stb), .wbm_we_o(b_we), .wbm_sel_o(b_sel),
        .wbm_adr_o(b_adr), .wbm_dat_o(b_dat_o), .wbm_dat_i(b_dat_i), .wbm_ack_i(b_ack)
    );

    assign b_widx  = 3'(b_adr >> 2);
    assign b_dat_i = b_mem[b_widx];
    assign b_ack   = b_cyc & b_stb;

    always @(posedge clk) begin
        if (b_ack && b_we) b_mem[b_widx] <= b_dat_o;
    end

    always @(negedge clk) begin
        if (b_ack && b_n < 80) begin
            b_log_adr[b_n] <= b_adr;
            b_log_dat[b_n] <= b_dat_o;
            b_log_we[b_n]  <= b_we;
            b_n <= b_n + 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulses start, returns the clock count from the start edge (=1) to the edge setting done_o.
    task automatic run_a(input int pulse_at, input int budget, output int n);
        @(negedge clk);
        a_start = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        a_start = 1'b0;
        while (a_done !== 1'b1 && n < budget) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            a_start = (n == pulse_at) ? 1'b1 : 1'b0;
        end
        a_start = 1'b0;
        check("run_a_finished", 32'(a_done), 32'h1);
    endtask

    int n, x0, c0, guard;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_busy", 32'(a_busy), 32'h0);
        check("rst_done", 32'(a_done), 32'h0);
        check("rst_pass", 32'(a_pass), 32'h0);
        check("rst_err", 32'(a_err), 32'h0);
        check("rst_cyc", 32'(a_cyc), 32'h0);
        check("rst_timeout", 32'(a_timeout), 32'h0);

        // Fault-free zero-wait run, with a stray start mid-run
        x0 = a_xfers;
        run_a(100, 400, n);
        check("ff_cycles", 32'(n), 32'd242);
        check("ff_pass", 32'(a_pass), 32'h1);
        check("ff_err", 32'(a_err), 32'h0);
        check("ff_busy", 32'(a_busy), 32'h0);
        check("ff_xfers", 32'(a_xfers - x0), 32'd80);
        check("ff_sel", 32'(a_selbad), 32'h0);
        @(negedge clk);
        check("ff_done_sticky", 32'(a_done), 32'h1);

        // Four wait states per ack
        a_waits = 4;
        x0 = a_xfers;
        run_a(0, 800, n);
        check("ws_cycles", 32'(n), 32'd562);
        check("ws_pass", 32'(a_pass), 32'h1);
        check("ws_err", 32'(a_err), 32'h0);
        check("ws_xfers", 32'(a_xfers - x0), 32'd80);
        check("ws_hold", 32'(a_holdbad), 32'h0);
        a_waits = 0;

        // Stuck-at-1 on bit 0 of word 5
        a_stuck = 1'b1;
        run_a(0, 400, n);
        check("sa_pass", 32'(a_pass), 32'h0);
        check("sa_err", 32'(a_err), 32'd3);
        check("sa_faddr", a_faddr, 32'h0001_0014);
        check("sa_fexp", a_fexp, 32'h0);
        check("sa_fact", a_fact, 32'h1);
        a_stuck = 1'b0;

        // New start clears sticky results; then reset mid-transfer
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check("rs_done_clr", 32'(a_done), 32'h0);
        check("rs_err_clr", 32'(a_err), 32'h0);
        check("rs_busy", 32'(a_busy), 32'h1);
        guard = 0;
        while (a_stb !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("rs_stb_seen", 32'(a_stb), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rs_cyc", 32'(a_cyc), 32'h0);
        check("rs_stb", 32'(a_stb), 32'h0);
        check("rs_adr", a_adr, 32'h0);
        check("rs_busy0", 32'(a_busy), 32'h0);
        check("rs_faddr", a_faddr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_a(0, 400, n);
        check("rs_cycles", 32'(n), 32'd242);
        check("rs_pass", 32'(a_pass), 32'h1);
        check("idle_bus", 32'(a_idlebad), 32'h0);

`ifdef SRAM_BIST_TIMEOUT_EN
        a_noack = 1'b1;
        c0 = a_cyccnt;
        run_a(0, 200, n);
        check("to_timeout", 32'(a_timeout), 32'h1);
        check("to_done", 32'(a_done), 32'h1);
        check("to_pass", 32'(a_pass), 32'h0);
        check("to_cyc_cycles", 32'(a_cyccnt - c0), 32'd16);
        check("to_cyc", 32'(a_cyc), 32'h0);
        a_noack = 1'b0;
`else
        check("no_timeout", 32'(a_timeout), 32'h0);
`endif

        // Non-zero background on instance B
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        guard = 0;
        while (b_done !== 1'b1 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("bg_done", 32'(b_done), 32'h1);
        check("bg_pass", 32'(b_pass), 32'h1);
        check("bg_xfers", 32'(b_n), 32'd80);
        check("bg_first_dat", b_log_dat[0], 32'hA5A5_5A5A);
        check("bg_first_we", 32'(b_log_we[0]), 32'h1);
        check("bg_m1_read_we", 32'(b_log_we[8]), 32'h0);
        check("bg_m1_write", b_log_dat[9], 32'h5A5A_A5A5);
        check("bg_m3_write", b_log_dat[41], 32'h5A5A_A5A5);
        for (int k = 0; k < 8; k++) begin
            check("bg_m3_adr", b_log_adr[40 + 2 * k], 32'h1C - 32'(4 * k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
